// File: rtl/nested_index_counter_if.sv
// Index stream between the nested counter and the address generators.
//   valid : idx is a valid beat (producer)
//   ready : consumer accepts the current beat
//   idx   : packed per-level index, level 0 in the low WIDTH bits
//   last  : current beat is the final beat of the run
//   wrap  : per-level registered wrap pulse
// master = counter side, slave = consumer side.
interface nested_index_counter_if #(
    parameter int WIDTH  = 8,
    parameter int LEVELS = 2
);
    logic                    valid;
    logic                    ready;
    logic [LEVELS*WIDTH-1:0] idx;
    logic                    last;
    logic [LEVELS-1:0]       wrap;

    modport master (output valid, idx, last, wrap, input ready);
    modport slave  (input valid, idx, last, wrap, output ready);
endinterface

// File: rtl/nested_index_counter.sv
// Nested loop index generator: LEVELS cascaded counters, each with a
// maximum latched at start, streamed out over a valid/ready handshake.
// Ports:
//   CLOCK   : clock, rising edge
//   resetn  : synchronous, active-low reset
//   start   : begin a run (honoured only in IDLE)
//   max_in  : per-level inclusive maxima, sampled on an accepted start
//   bus     : index stream (valid/ready/idx/last/wrap), master side
//   busy    : run in progress
//   done    : one-cycle pulse at end of run
//
// state | meaning
// IDLE  | waiting for start, no beats offered
// RUN   | offering idx beats, advancing on valid && ready
// DONE  | one-cycle done pulse, then back to IDLE
module nested_index_counter #(
    parameter int WIDTH  = 8,
    parameter int LEVELS = 2
) (
    input  logic                     CLOCK,
    input  logic                     resetn,
    input  logic                     start,
    input  logic [LEVELS*WIDTH-1:0]  max_in,
    nested_index_counter_if.master   bus,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [LEVELS-1:0][WIDTH-1:0]  idx_q, idx_d;
    logic [LEVELS-1:0][WIDTH-1:0]  max_q, max_d;
    logic [LEVELS-1:0]             wrap_q, wrap_d;
    logic [LEVELS-1:0]             at_max;
    logic                          accept;
    logic                          carry;

    always_comb begin
        for (int k = 0; k < LEVELS; k++) begin
            at_max[k] = (idx_q[k] == max_q[k]);
        end
    end

    // valid is a pure decode of the state register, so ready never
    // reaches valid combinationally.
    assign accept = (state_q == RUN) && bus.ready;

    always_ff @(posedge CLOCK) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            max_q   <= '0;
            wrap_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            max_q   <= max_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        max_d   = max_q;
        wrap_d  = '0;
        carry   = 1'b1;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    max_d   = max_in;
                    idx_d   = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    // carry into level k means every lower level was at max;
                    // after the update it tells whether levels 0..k all wrapped.
                    for (int k = 0; k < LEVELS; k++) begin
                        if (carry) begin
                            if (at_max[k]) begin
                                idx_d[k] = '0;
                            end else begin
                                idx_d[k] = idx_q[k] + WIDTH'(1);
                            end
                        end
                        carry     = carry & at_max[k];
                        wrap_d[k] = carry;
                    end
                    // final beat: every level wraps, so idx is already back at 0
                    if (&at_max) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.valid = (state_q == RUN);
    assign bus.idx   = idx_q;
    assign bus.last  = bus.valid && (&at_max);
    assign bus.wrap  = wrap_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_nested_index_counter.sv
module tb_nested_index_counter;

    logic        CLOCK;
    logic        resetn;
    logic        start;
    logic [15:0] max_in;
    logic        busy;
    logic        done;

    nested_index_counter_if #(.WIDTH(8), .LEVELS(2)) bus ();

    nested_index_counter #(.WIDTH(8), .LEVELS(2)) dut (
        .CLOCK  (CLOCK),
        .resetn (resetn),
        .start  (start),
        .max_in (max_in),
        .bus    (bus.master),
        .busy   (busy),
        .done   (done)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [15:0] idx;
        logic        last;
        logic [1:0]  wrap;
    } beat_t;

    beat_t sb[$];

    int tests = 0;
    int fails = 0;

    logic        chk_en   = 1'b0;
    logic [1:0]  exp_wrap = 2'b00;
    logic        exp_done = 1'b0;
    logic        stall_v  = 1'b0;
    logic [15:0] stall_idx;
    logic        stall_last;
    int          acc_cnt  = 0;
    int          done_cnt = 0;

    logic        bp  = 1'b0;
    logic [5:0]  pat = 6'b101001;   // ready sequence 1,0,0,1,0,1 from bit 0
    int          ph  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ready driver
    initial begin
        bus.ready = 1'b1;
        forever begin
            @(posedge CLOCK);
            #1;
            if (bp) begin
                bus.ready = pat[ph];
                ph = (ph + 1) % 6;
            end else begin
                bus.ready = 1'b1;
            end
        end
    end

    // monitor / scoreboard
    always @(negedge CLOCK) begin
        if (chk_en) begin
            chk("wrap", {30'd0, bus.wrap}, {30'd0, exp_wrap});
            chk("done", {31'd0, done}, {31'd0, exp_done});
            if (done) done_cnt++;
            if (stall_v && resetn) begin
                chk("stall_valid", {31'd0, bus.valid}, 32'd1);
                chk("stall_idx", {16'd0, bus.idx}, {16'd0, stall_idx});
                chk("stall_last", {31'd0, bus.last}, {31'd0, stall_last});
            end
            exp_wrap = 2'b00;
            exp_done = 1'b0;
            stall_v  = 1'b0;
            if (resetn && bus.valid && bus.ready) begin
                acc_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_beat", {16'd0, bus.idx}, 32'hFFFF_FFFF);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("beat_idx", {16'd0, bus.idx}, {16'd0, e.idx});
                    chk("beat_last", {31'd0, bus.last}, {31'd0, e.last});
                    exp_wrap = e.wrap;
                    exp_done = e.last;
                end
            end else if (resetn && bus.valid) begin
                stall_v    = 1'b1;
                stall_idx  = bus.idx;
                stall_last = bus.last;
            end
        end
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic push(input logic [7:0] l1, input logic [7:0] l0,
                        input logic last, input logic [1:0] wrap);
        beat_t b;
        b.idx  = {l1, l0};
        b.last = last;
        b.wrap = wrap;
        sb.push_back(b);
    endtask

    task automatic push_basic();
        push(8'd0, 8'd0, 1'b0, 2'b00);
        push(8'd0, 8'd1, 1'b0, 2'b00);
        push(8'd0, 8'd2, 1'b0, 2'b01);
        push(8'd1, 8'd0, 1'b0, 2'b00);
        push(8'd1, 8'd1, 1'b0, 2'b00);
        push(8'd1, 8'd2, 1'b1, 2'b11);
    endtask

    task automatic do_start(input logic [15:0] m);
        acc_cnt  = 0;
        done_cnt = 0;
        start    = 1'b1;
        max_in   = m;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input string name, input int beats);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(negedge CLOCK);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_done_seen"}, {31'd0, seen}, 32'd1);
        chk({name, "_sb_empty"}, sb.size(), 32'd0);
        chk({name, "_beats"}, acc_cnt, beats);
        chk({name, "_busy_in_done"}, {31'd0, busy}, 32'd1);
        @(negedge CLOCK);
        chk({name, "_busy_after"}, {31'd0, busy}, 32'd0);
        chk({name, "_valid_after"}, {31'd0, bus.valid}, 32'd0);
        chk({name, "_idx_after"}, {16'd0, bus.idx}, 32'd0);
        repeat (3) @(negedge CLOCK);
        chk({name, "_done_count"}, done_cnt, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        resetn = 1'b0;
        start  = 1'b1;
        max_in = 16'h0102;
        tick();
        tick();
        @(negedge CLOCK);
        chk("rst_valid", {31'd0, bus.valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_wrap", {30'd0, bus.wrap}, 32'd0);
        chk("rst_idx", {16'd0, bus.idx}, 32'd0);
        chk("rst_last", {31'd0, bus.last}, 32'd0);
        tick();
        resetn = 1'b1;
        start  = 1'b0;
        chk_en = 1'b1;
        tick();

        // basic nest
        push_basic();
        do_start(16'h0102);
        wait_done("basic", 6);

        // backpressure
        bp = 1'b1;
        ph = 0;
        push_basic();
        do_start(16'h0102);
        wait_done("bp", 6);
        bp = 1'b0;
        tick();

        // degenerate: all max = 0
        push(8'd0, 8'd0, 1'b1, 2'b11);
        do_start(16'h0000);
        wait_done("degen", 1);

        // full range level 0
        for (int i = 0; i < 256; i++) begin
            push(8'd0, 8'(i), (i == 255), (i == 255) ? 2'b11 : 2'b00);
        end
        do_start(16'h00FF);
        wait_done("full", 256);

        // start and max_in changes ignored mid-run
        push_basic();
        do_start(16'h0102);
        tick();
        start  = 1'b1;
        max_in = 16'h0707;
        tick();
        start  = 1'b0;
        wait_done("ignore", 6);

        // reset mid-run at idx (1,0)
        push_basic();
        do_start(16'h0102);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK);
            if (bus.valid && bus.idx == 16'h0002) begin
                found = 1'b1;
                break;
            end
        end
        chk("midrst_found", {31'd0, found}, 32'd1);
        tick();
        chk("midrst_at_10", {16'd0, bus.idx}, 32'h0100);
        resetn = 1'b0;
        tick();
        sb.delete();
        chk("midrst_valid", {31'd0, bus.valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_idx", {16'd0, bus.idx}, 32'd0);
        resetn = 1'b1;
        repeat (3) @(negedge CLOCK);
        chk("midrst_no_done", done_cnt, 32'd0);
        tick();

        // restart after reset
        push_basic();
        do_start(16'h0102);
        wait_done("restart", 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nested_index_counter.md
Name: nested_index_counter

Overview:
- Parametrised successor to the single-level terminal counter.
- Generates a nested loop index (LEVELS cascaded counters, each with a runtime-loaded maximum) for NN layer iteration, e.g. inner = input index, outer = neuron index.
- Adds start/busy/done sequencing, a valid/ready output handshake with backpressure, and per-level wrap flags.
- Sits between the layer controller and the weight/activation address generators.

Parameters:
- WIDTH, 8, bit width of each level's index and maximum.
- LEVELS, 2, number of nested levels (1..4). Level 0 is innermost, in the low bits of packed buses.

Ports:
- CLOCK  input  1  clock, rising edge.
- resetn  input  1  synchronous, active-low reset.
- start  input  1  begin a run; honoured only in IDLE.
- max_in  input  LEVELS*WIDTH  per-level inclusive maximum; level k at bits [k*WIDTH +: WIDTH]; sampled on accepted start.
- ready  input  1  downstream accepts the current index.
- valid  output  1  idx is a valid beat.
- idx  output  LEVELS*WIDTH  current packed index, same packing as max_in.
- last  output  1  current beat is the final beat of the run.
- wrap  output  LEVELS  per-level one-cycle wrap pulse (registered).
- busy  output  1  run in progress (state != IDLE).
- done  output  1  one-cycle pulse at end of run.

Behaviour:
- Reset:
  - clocked on CLOCK; resetn synchronous, active-low.
  - while resetn=0 at an edge: state=IDLE; idx, valid, wrap, busy, done all 0; latched maxima 0. last=0 follows since valid=0.
  - reset wins over every other input, including mid-run: the run is abandoned with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - valid=0, busy=0.
  - start=1 at an edge: latch max_in, set idx=0, go to RUN. valid=1 from the next cycle.
- RUN:
  - valid=1, busy=1.
  - A beat is accepted at an edge with valid&&ready.
  - On an accepted beat, level 0 increments. If level k == its max, it resets to 0 and carries into level k+1. Level k only changes when every lower level is at its max.
  - valid&&!ready: idx, last, valid are held unchanged (stall); wrap=0.
- last (combinational): valid && every level == its latched max.
- wrap[k]: registered; 1 for exactly the cycle after an accepted beat in which levels 0..k were all at max, otherwise 0. On the final beat all wrap bits pulse together.
- Accepted beat with last=1:
  - go to DONE; idx returns to 0; valid=0.
- DONE:
  - lasts one cycle: done=1, busy=1, valid=0; then return to IDLE.
- Run length: exactly product over k of (max_k+1) accepted beats.
- Boundaries:
  - max_k=0: level k is always 0 (count of 1).
  - all max=0: a single beat, with last=1 on the first valid cycle.
  - max_k=2^WIDTH-1: full-range wrap, no overflow beyond WIDTH.
- start in RUN or DONE: ignored; no restart and no re-latch.
- max_in changes during a run: no effect, since maxima are latched.
- No combinational path from ready to valid. idx and valid come from registers.

Test Plan:
- Reset: hold resetn=0 for 2 cycles with start=1 -> valid=0, busy=0, done=0, wrap=0, idx=0.
- Basic nest (max0=2, max1=1, ready=1):
  - start -> 6 consecutive valid beats with idx (l1,l0) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - last only on beat 6.
  - wrap[0] pulses after beats 3 and 6; wrap[1] only after beat 6.
  - done=1 on the cycle after beat 6, then busy=0.
- Backpressure (same maxima, ready pattern 1,0,0,1,0,1...):
  - idx and last stay stable while ready=0.
  - sequence identical to the basic-nest test; total accepted beats=6.
- Degenerate and full-range:
  - all max=0 -> one beat, idx=0, last=1, wrap=2'b11 next cycle, then done.
  - max0=255, max1=0 -> 256 beats, level 0 wraps 255->0 with no spill into level 1 bits.
- Ignored inputs: start pulsed mid-run, and max_in changed to 7/7 mid-run -> run completes with the original 6 beats and a single done pulse.
- Reset mid-run:
  - assert resetn=0 at idx (1,0) -> next cycle valid=0, busy=0, idx=0, no done pulse.
  - a subsequent start restarts from (0,0).
